// File: rtl/uart_rx_param_pkg.sv
// Shared UART definitions: parity codes, receiver FSM states and the default bit period.
// Intended for reuse by the transmitter as well.
package uart_rx_param_pkg;

    localparam int unsigned PARITY_NONE          = 0;
    localparam int unsigned PARITY_ODD           = 1;
    localparam int unsigned PARITY_EVEN          = 2;
    localparam int unsigned DEFAULT_CLKS_PER_BIT = 868;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK
    } rx_state_t;

    function automatic logic majority3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Receive-line front end: preset-to-idle synchroniser, falling-edge detect and
// a 3-tap majority over the current and two previous synchronised samples.
module uart_rx_sampler
    import uart_rx_param_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic rx,
    output logic rx_s,
    output logic fall,
    output logic vote
);

    logic [SYNC_STAGES-1:0] sync;
    logic [1:0]             hist;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync <= '1;
            hist <= '1;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], rx};
            hist <= {hist[0], sync[SYNC_STAGES-1]};
        end
    end

    assign rx_s = sync[SYNC_STAGES-1];
    assign fall = hist[0] & ~rx_s;
    // Evaluated at count M+1, this covers the samples taken at M-1, M and M+1.
    assign vote = majority3(rx_s, hist[0], hist[1]);

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: majority-voted sampling, optional parity, 1 or 2 stop bits,
// error pulses and a valid/ready output register with overrun reporting.
module uart_rx_param
    import uart_rx_param_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
    parameter int unsigned DATA_BITS    = 8,
    parameter int unsigned PARITY       = PARITY_NONE,
    parameter int unsigned STOP_BITS    = 1,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int unsigned   CW         = $clog2(CLKS_PER_BIT);
    localparam int unsigned   BW         = $clog2(DATA_BITS + 1);
    localparam logic [CW-1:0] SAMPLE_AT  = CW'(CLKS_PER_BIT / 2 + 1);
    localparam logic [CW-1:0] LAST_CNT   = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BIT   = BW'(DATA_BITS - 1);
    localparam logic          LAST_STOP  = (STOP_BITS == 2);
    // Required XOR over payload plus parity bit.
    localparam logic          PAR_EXPECT = (PARITY == PARITY_ODD);

    rx_state_t            state, state_next;
    logic [CW-1:0]        cnt, cnt_next;
    logic [BW-1:0]        bit_idx, bit_idx_next;
    logic                 stop_idx, stop_idx_next;
    logic [DATA_BITS-1:0] shreg, shreg_next;
    logic                 par_acc, par_acc_next;
    logic                 par_bad, par_bad_next;
    logic                 sample, deliver, frame_fail, parity_fail;
    logic                 rx_s, fall, vote;

    uart_rx_sampler #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sampler (
        .clk  (clk),
        .reset(reset),
        .rx   (rx),
        .rx_s (rx_s),
        .fall (fall),
        .vote (vote)
    );

    // The bit counter free-runs with wrap from the start bit onwards, so every
    // bit, including the first data bit, is sampled at the same count.
    always_comb begin
        state_next    = state;
        cnt_next      = (cnt == LAST_CNT) ? '0 : cnt + 1'b1;
        bit_idx_next  = bit_idx;
        stop_idx_next = stop_idx;
        shreg_next    = shreg;
        par_acc_next  = par_acc;
        par_bad_next  = par_bad;
        deliver       = 1'b0;
        frame_fail    = 1'b0;
        parity_fail   = 1'b0;
        sample        = (cnt == SAMPLE_AT);
        unique case (state)
            ST_IDLE: begin
                cnt_next = '0;
                if (fall) state_next = ST_START;
            end
            ST_START: begin
                if (sample) begin
                    if (vote) begin
                        state_next = ST_IDLE;
                    end else begin
                        state_next    = ST_DATA;
                        bit_idx_next  = '0;
                        stop_idx_next = 1'b0;
                        par_acc_next  = 1'b0;
                        par_bad_next  = 1'b0;
                    end
                end
            end
            ST_DATA: begin
                if (sample) begin
                    shreg_next   = {vote, shreg[DATA_BITS-1:1]};
                    par_acc_next = par_acc ^ vote;
                    if (bit_idx == LAST_BIT) begin
                        state_next = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
                    end else begin
                        bit_idx_next = bit_idx + 1'b1;
                    end
                end
            end
            ST_PARITY: begin
                if (sample) begin
                    par_bad_next = ((par_acc ^ vote) != PAR_EXPECT);
                    state_next   = ST_STOP;
                end
            end
            ST_STOP: begin
                if (sample) begin
                    if (!vote) begin
                        frame_fail = 1'b1;
                        state_next = ST_BREAK;
                    end else if (stop_idx == LAST_STOP) begin
                        parity_fail = par_bad;
                        deliver     = ~par_bad;
                        state_next  = ST_IDLE;
                    end else begin
                        stop_idx_next = 1'b1;
                    end
                end
            end
            ST_BREAK: begin
                cnt_next = '0;
                if (rx_s) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            bit_idx  <= '0;
            stop_idx <= 1'b0;
            shreg    <= '0;
            par_acc  <= 1'b0;
            par_bad  <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            bit_idx  <= bit_idx_next;
            stop_idx <= stop_idx_next;
            shreg    <= shreg_next;
            par_acc  <= par_acc_next;
            par_bad  <= par_bad_next;
            busy     <= !(state_next inside {ST_IDLE, ST_START});
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            frame_err  <= frame_fail;
            parity_err <= parity_fail;
            overrun    <= deliver & rx_valid & ~rx_ready;
            if (deliver && (!rx_valid || rx_ready)) begin
                rx_data  <= shreg;
                rx_valid <= 1'b1;
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule
